// File: rtl/bus_port_endpoint.sv
// bus_port_endpoint
//
// Device-side endpoint for one driver port of the bus generator/arbiter.
// The local host writes packets into a TX FIFO, and the bus drains that FIFO
// through pndng/D_pop/pop. The bus delivers packets on push/D_push. Packets
// addressed to this port, or to the broadcast ID, go into an RX FIFO that the
// host drains.
//
// Ports
//   clk, reset                     : single clock; asynchronous active-high reset
//   host_wr_valid/_data/_ready     : host -> TX FIFO write handshake
//   pndng, D_pop, pop              : TX FIFO head presented to the bus
//   push, D_push                   : bus delivery into the RX filter/FIFO
//   host_rd_valid/_data/_ready     : RX FIFO head presented to the host
//   tx_count, rx_count             : FIFO occupancy
//   rx_overflow, tx_underflow      : sticky error flags
//   rx_filtered                    : saturating count of address-mismatch drops
module bus_port_endpoint #(
  parameter int         pckg_sz    = 16,
  parameter int         fifo_depth = 16,
  parameter logic [7:0] id         = 8'd0,
  parameter logic [7:0] broadcast  = {8{1'b1}}
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               host_wr_valid,
  input  logic [pckg_sz-1:0]                 host_wr_data,
  output logic                               host_wr_ready,
  output logic                               pndng,
  output logic [pckg_sz-1:0]                 D_pop,
  input  logic                               pop,
  input  logic                               push,
  input  logic [pckg_sz-1:0]                 D_push,
  output logic                               host_rd_valid,
  output logic [pckg_sz-1:0]                 host_rd_data,
  input  logic                               host_rd_ready,
  output logic [$clog2(fifo_depth+1)-1:0]    tx_count,
  output logic [$clog2(fifo_depth+1)-1:0]    rx_count,
  output logic                               rx_overflow,
  output logic                               tx_underflow,
  output logic [7:0]                         rx_filtered
);

  localparam int CW = $clog2(fifo_depth + 1);
  localparam int PW = $clog2(fifo_depth);
  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);
  localparam logic [PW-1:0] LAST_C  = PW'(fifo_depth - 1);

  // Pointers wrap explicitly so that non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Storage is left unreset; only pointers and counts define validity.
  logic [pckg_sz-1:0] tx_mem [fifo_depth];
  logic [pckg_sz-1:0] rx_mem [fifo_depth];

  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic          rx_overflow_q, rx_overflow_d;
  logic          tx_underflow_q, tx_underflow_d;
  logic [7:0]    rx_filtered_q, rx_filtered_d;

  logic          tx_wr, tx_rd, rx_wr, rx_rd;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    dest;
  logic          addr_match;

  // Full/empty come from registered counts only, so a read in the same cycle
  // never makes room for a write.
  assign tx_full  = (tx_count_q == DEPTH_C);
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == DEPTH_C);
  assign rx_empty = (rx_count_q == '0);

  assign dest       = D_push[pckg_sz-1 -: 8];
  assign addr_match = (dest == id) || (dest == broadcast);

  assign tx_wr = host_wr_valid && !tx_full;
  assign tx_rd = pop && !tx_empty;
  assign rx_wr = push && addr_match && !rx_full;
  assign rx_rd = host_rd_ready && !rx_empty;

  always_comb begin
    tx_wr_ptr_d    = tx_wr_ptr_q;
    tx_rd_ptr_d    = tx_rd_ptr_q;
    rx_wr_ptr_d    = rx_wr_ptr_q;
    rx_rd_ptr_d    = rx_rd_ptr_q;
    tx_count_d     = tx_count_q;
    rx_count_d     = rx_count_q;
    rx_overflow_d  = rx_overflow_q;
    tx_underflow_d = tx_underflow_q;
    rx_filtered_d  = rx_filtered_q;

    if (tx_wr) tx_wr_ptr_d = ptr_inc(tx_wr_ptr_q);
    if (tx_rd) tx_rd_ptr_d = ptr_inc(tx_rd_ptr_q);
    if (rx_wr) rx_wr_ptr_d = ptr_inc(rx_wr_ptr_q);
    if (rx_rd) rx_rd_ptr_d = ptr_inc(rx_rd_ptr_q);

    case ({tx_wr, tx_rd})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase

    case ({rx_wr, rx_rd})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase

    if (pop && tx_empty) tx_underflow_d = 1'b1;
    if (push && addr_match && rx_full) rx_overflow_d = 1'b1;
    if (push && !addr_match && (rx_filtered_q != 8'hFF))
      rx_filtered_d = rx_filtered_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr_q    <= '0;
      tx_rd_ptr_q    <= '0;
      rx_wr_ptr_q    <= '0;
      rx_rd_ptr_q    <= '0;
      tx_count_q     <= '0;
      rx_count_q     <= '0;
      rx_overflow_q  <= 1'b0;
      tx_underflow_q <= 1'b0;
      rx_filtered_q  <= '0;
    end else begin
      tx_wr_ptr_q    <= tx_wr_ptr_d;
      tx_rd_ptr_q    <= tx_rd_ptr_d;
      rx_wr_ptr_q    <= rx_wr_ptr_d;
      rx_rd_ptr_q    <= rx_rd_ptr_d;
      tx_count_q     <= tx_count_d;
      rx_count_q     <= rx_count_d;
      rx_overflow_q  <= rx_overflow_d;
      tx_underflow_q <= tx_underflow_d;
      rx_filtered_q  <= rx_filtered_d;
    end
  end

  // Writes are gated by the registered full flag. While reset is high that
  // flag reads "empty", so a write may land in storage during reset; this is
  // harmless because the pointers still read zero.
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wr_ptr_q] <= host_wr_data;
    if (rx_wr) rx_mem[rx_wr_ptr_q] <= D_push;
  end

  // The FIFOs are first-word-fall-through: the head is read combinationally
  // through the registered read pointer.
  assign D_pop         = tx_mem[tx_rd_ptr_q];
  assign host_rd_data  = rx_mem[rx_rd_ptr_q];
  assign pndng         = !tx_empty;
  assign host_wr_ready = !tx_full;
  assign host_rd_valid = !rx_empty;
  assign tx_count      = tx_count_q;
  assign rx_count      = rx_count_q;
  assign rx_overflow   = rx_overflow_q;
  assign tx_underflow  = tx_underflow_q;
  assign rx_filtered   = rx_filtered_q;

endmodule

// File: tb/tb_bus_port_endpoint.sv
// Testbench for bus_port_endpoint (pckg_sz=16, fifo_depth=16, id=0x02).
// The reference model keeps queues and flags. A negedge compare process checks
// every output against that model, and the directed stimulus adds literal
// expectations at key points.
module tb_bus_port_endpoint;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_wr_valid = 1'b0;
  logic [15:0] host_wr_data = '0;
  logic        host_wr_ready;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        host_rd_valid;
  logic [15:0] host_rd_data;
  logic        host_rd_ready = 1'b0;
  logic [4:0]  tx_count, rx_count;
  logic        rx_overflow, tx_underflow;
  logic [7:0]  rx_filtered;

  int checks = 0;
  int errors = 0;

  bus_port_endpoint #(.pckg_sz(16), .fifo_depth(DEPTH), .id(8'h02)) dut (
    .clk(clk), .reset(reset),
    .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data), .host_rd_ready(host_rd_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .tx_underflow(tx_underflow), .rx_filtered(rx_filtered)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic        m_ovf, m_unf;
  int          m_filt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_ovf  <= 1'b0;
      m_unf  <= 1'b0;
      m_filt <= 0;
    end else begin
      automatic int  tsz = tx_q.size();
      automatic int  rsz = rx_q.size();
      automatic logic [7:0] d = D_push[15:8];
      if (pop && tsz == 0) m_unf <= 1'b1;
      if (pop && tsz > 0) void'(tx_q.pop_front());
      if (host_wr_valid && tsz < DEPTH) tx_q.push_back(host_wr_data);
      if (host_rd_ready && rsz > 0) void'(rx_q.pop_front());
      if (push) begin
        if (d != 8'h02 && d != 8'hFF) begin
          if (m_filt < 255) m_filt <= m_filt + 1;
        end else if (rsz == DEPTH) begin
          m_ovf <= 1'b1;
        end else begin
          rx_q.push_back(D_push);
        end
      end
    end
  end

  // Compare every cycle while the DUT is out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp_pndng", pndng, tx_q.size() != 0);
      chk("cmp_wr_ready", host_wr_ready, tx_q.size() != DEPTH);
      chk("cmp_tx_count", tx_count, tx_q.size());
      if (tx_q.size() != 0) chk("cmp_D_pop", D_pop, tx_q[0]);
      chk("cmp_rd_valid", host_rd_valid, rx_q.size() != 0);
      chk("cmp_rx_count", rx_count, rx_q.size());
      if (rx_q.size() != 0) chk("cmp_rd_data", host_rd_data, rx_q[0]);
      chk("cmp_rx_overflow", rx_overflow, m_ovf);
      chk("cmp_tx_underflow", tx_underflow, m_unf);
      chk("cmp_rx_filtered", rx_filtered, m_filt);
    end
  end

  // Advance one clock; return shortly after the following negedge so inputs
  // change away from the active edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_pndng", pndng, 0);
    chk("rst_wr_ready", host_wr_ready, 1);
    chk("rst_rd_valid", host_rd_valid, 0);
    reset = 1'b0;
    cyc();
    $display("reset released: tx_count=%0d rx_count=%0d", tx_count, rx_count);

    // TX ordering
    host_wr_valid = 1'b1;
    host_wr_data = 16'h0101; cyc(); chk("tx_cnt1", tx_count, 1); chk("tx_head1", D_pop, 16'h0101);
    host_wr_data = 16'h0202; cyc(); chk("tx_cnt2", tx_count, 2);
    host_wr_data = 16'h0303; cyc(); chk("tx_cnt3", tx_count, 3); chk("tx_head_a", D_pop, 16'h0101);
    host_wr_valid = 1'b0; pop = 1'b1;
    cyc(); chk("tx_cnt2b", tx_count, 2); chk("tx_head_b", D_pop, 16'h0202);
    cyc(); chk("tx_cnt1b", tx_count, 1); chk("tx_head_c", D_pop, 16'h0303);
    cyc(); chk("tx_cnt0", tx_count, 0); chk("tx_pndng0", pndng, 0);
    pop = 1'b0;
    $display("tx ordering done");

    // TX full
    host_wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_wr_data = 16'h1000 + 16'(i);
      cyc();
    end
    chk("tx_full_ready", host_wr_ready, 0);
    chk("tx_full_cnt", tx_count, 16);
    host_wr_data = 16'hDEAD; pop = 1'b1;
    cyc();
    chk("tx_17th_cnt", tx_count, 15);
    host_wr_valid = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    chk("tx_drained", pndng, 0);
    chk("tx_unf_before", tx_underflow, 0);
    cyc();
    chk("tx_underflow", tx_underflow, 1);
    pop = 1'b0;
    $display("tx full/underflow done");

    // RX filter
    push = 1'b1;
    D_push = 16'h02AA; cyc(); chk("rx_valid_lat", host_rd_valid, 1);
    D_push = 16'hFF55; cyc();
    D_push = 16'h0377; cyc();
    push = 1'b0;
    chk("rx_filt1", rx_filtered, 1);
    chk("rx_cnt2", rx_count, 2);
    chk("rx_head_a", host_rd_data, 16'h02AA);
    host_rd_ready = 1'b1;
    cyc(); chk("rx_head_b", host_rd_data, 16'hFF55);
    cyc(); chk("rx_empty", host_rd_valid, 0);
    host_rd_ready = 1'b0;
    $display("rx filter done");

    // RX overflow
    push = 1'b1;
    for (int i = 0; i < 18; i++) begin
      D_push = 16'h0200 + 16'(i);
      cyc();
    end
    push = 1'b0;
    chk("rx_ovf_cnt", rx_count, 16);
    chk("rx_ovf_flag", rx_overflow, 1);
    host_rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("rx_drain", host_rd_data, 16'h0200 + 16'(i));
      cyc();
    end
    chk("rx_drain_cnt", rx_count, 0);
    // Wrap: simultaneous push and read
    push = 1'b1;
    for (int i = 0; i < 20; i++) begin
      D_push = 16'h02B0 + 16'(i);
      cyc();
    end
    push = 1'b0;
    cyc();
    chk("rx_wrap_cnt", rx_count, 0);
    host_rd_ready = 1'b0;
    $display("rx overflow/wrap done");

    // Saturation
    push = 1'b1;
    for (int i = 0; i < 300; i++) begin
      D_push = {8'h05, 8'(i)};
      cyc();
    end
    push = 1'b0;
    chk("rx_filt_sat", rx_filtered, 255);
    $display("saturation done");

    // Asynchronous reset with both FIFOs non-empty
    host_wr_valid = 1'b1; host_wr_data = 16'h0A0A; push = 1'b1; D_push = 16'h02C0;
    cyc(); cyc();
    host_wr_valid = 1'b0; push = 1'b0;
    chk("pre_rst_tx", tx_count, 2);
    chk("pre_rst_rx", rx_count, 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pndng", pndng, 0);
    chk("arst_rd_valid", host_rd_valid, 0);
    chk("arst_wr_ready", host_wr_ready, 1);
    chk("arst_tx_cnt", tx_count, 0);
    chk("arst_rx_cnt", rx_count, 0);
    chk("arst_ovf", rx_overflow, 0);
    chk("arst_unf", tx_underflow, 0);
    chk("arst_filt", rx_filtered, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    host_wr_valid = 1'b1; host_wr_data = 16'h0ABC;
    cyc();
    host_wr_valid = 1'b0;
    chk("post_rst_cnt", tx_count, 1);
    chk("post_rst_head", D_pop, 16'h0ABC);
    cyc();
    $display("reset test done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_port_endpoint.md
# bus_port_endpoint

Device-side endpoint for one driver port of the bus generator/arbiter (`bs_gnrtr_n_rbtr`). It stores packets from the local host in a TX FIFO and presents them to the bus through `pndng`/`D_pop`/`pop`. It accepts bus deliveries on `push`/`D_push`, filters them by destination ID, and buffers accepted packets in an RX FIFO for the host. One instance sits on each `[bits][drvrs]` port slot, in place of the bench driver's FIFO model.

## Interface
- `pckg_sz`, default 16: packet width in bits. The destination ID is in `[pckg_sz-1 -: 8]`. Legal when `pckg_sz` ≥ 9.
- `fifo_depth`, default 16: entries in each FIFO. Any value ≥ 2 (not restricted to a power of 2).
- `id`, default 0: this port's 8-bit destination ID.
- `broadcast`, default `{8{1'b1}}`: destination ID that every port accepts.
- `clk` (in, 1): single clock; all logic is rising-edge.
- `reset` (in, 1): asynchronous, active-high. Clears all state.
- `host_wr_valid` (in, 1): host offers a TX packet.
- `host_wr_data` (in, `pckg_sz`): TX packet.
- `host_wr_ready` (out, 1): TX FIFO not full.
- `pndng` (out, 1): TX FIFO not empty (to bus).
- `D_pop` (out, `pckg_sz`): TX FIFO head (to bus).
- `pop` (in, 1): bus consumes the TX head.
- `push` (in, 1): bus delivers a packet.
- `D_push` (in, `pckg_sz`): delivered packet.
- `host_rd_valid` (out, 1): RX FIFO not empty.
- `host_rd_data` (out, `pckg_sz`): RX FIFO head.
- `host_rd_ready` (in, 1): host consumes the RX head.
- `tx_count`, `rx_count` (out, `$clog2(fifo_depth+1)`): FIFO occupancy.
- `rx_overflow` (out, 1): sticky; an accepted-address packet was dropped because the RX FIFO was full.
- `tx_underflow` (out, 1): sticky; `pop` arrived while the TX FIFO was empty.
- `rx_filtered` (out, 8): saturating count of packets dropped for address mismatch.

## Operation
- Both FIFOs are first-word-fall-through circular buffers, each with separate read/write pointers and an occupancy counter.
  - Pointers wrap from `fifo_depth-1` to 0.
  - `D_pop` and `host_rd_data` always show the head entry combinationally from storage. Their value is don't-care when the FIFO is empty.
- **TX write:** occurs when `host_wr_valid && host_wr_ready`.
  - `host_wr_ready = (tx_count != fifo_depth)`, evaluated from registered count.
  - A pop in the same cycle does not make room.
- **TX read:** occurs when `pop && pndng`.
  - `pop` while `!pndng` has no effect on data and sets `tx_underflow`.
- **RX accept:** on `push`, with `dest = D_push[pckg_sz-1 -: 8]`.
  - If `dest` is neither `id` nor `broadcast`, the packet is dropped and `rx_filtered` increments, saturating at 255.
  - Otherwise, if `rx_count == fifo_depth`, the packet is dropped and `rx_overflow` sets. A host read in the same cycle does not make room.
  - Otherwise the packet is written.
- **RX read:** occurs when `host_rd_ready && host_rd_valid`. A read while empty is ignored.
- **Simultaneous read and write** on the same FIFO when it is neither full nor empty: both occur and the count is unchanged.
- **Sticky flags:** cleared only by `reset`.
- **Reset** (asynchronous): takes effect immediately, mid-transfer included.
  - Pointers, counts, flags and `rx_filtered` go to 0.
  - Outputs go to `pndng=0`, `host_wr_ready=1`, `host_rd_valid=0`, `tx_count=0`, `rx_count=0`.
  - Storage contents are not cleared.
  - Operations presented in the cycle reset deasserts are lost only if `reset` is still high at that edge.

## Timing
- **TX:** a host write at edge N makes `pndng=1` and `D_pop` valid after edge N. The bus can pop at edge N+1.
- **TX pop:** a pop at edge N advances `D_pop` to the next entry, or drops `pndng`, after edge N.
- **RX:** a push at edge N makes `host_rd_valid=1` after edge N, giving 1-cycle latency.
- **Counts and status:** all registered, updated at the same edge as the operation.
- **Combinational paths:**
  - There is no input-to-output combinational path except head-data muxing from the registered read pointer.
  - `host_wr_ready`, `pndng` and `host_rd_valid` depend only on registers.
- **Throughput:** back-to-back operation at one packet per cycle in each direction, sustained indefinitely.

## Test plan
- **TX ordering:** with `id=0`, host writes 0x0101, 0x0202, 0x0303 on consecutive cycles, then the bus pops 3 times. Required: `D_pop` shows 0x0101/0x0202/0x0303 in order, `pndng` falls after the third pop, and `tx_count` follows 1,2,3,2,1,0.
- **TX full:** write 16 packets with `fifo_depth=16`. Required: `host_wr_ready=0` and `tx_count=16`. A 17th write with a simultaneous pop is refused, giving `tx_count=15`. An extra pop when empty sets `tx_underflow=1`.
- **RX filter:** with `id=2`, push 0x02AA, 0xFF55 and 0x0377. Required: the host reads 0x02AA then 0xFF55, `rx_filtered=1`, and `host_rd_valid` goes high the cycle after the first push.
- **RX overflow and wrap:** push 18 packets with dest 0x02 and no host reads. Required: `rx_count=16`, `rx_overflow=1`, and the host drains exactly the first 16 in order. Then push and read 20 more (pointer wrap) with no loss or reordering.
- **Saturation and reset:** push 300 mismatched packets. Required: `rx_filtered=255`. Then assert `reset` asynchronously mid-cycle while both FIFOs are non-empty. Required: all counts, flags and `rx_filtered` are 0, `pndng=0`, `host_rd_valid=0` and `host_wr_ready=1` without waiting for a clock edge.
